mfcc_log2_iter: RTL and testbench
=================================

# mfcc_log2_iter

Parametrised fixed-point logarithm unit for the MFCC front end. It sits between the mel filterbank accumulator and the DCT stage. It takes one non-negative mel-energy sample per handshake, tagged with its mel channel index. It returns the signed fixed-point log2 of the sample (or ln, see Configuration), computed with leading-one normalisation followed by iterative mantissa squaring, which produces one result bit per cycle. It replaces the earlier fixed-width log stage. It adds width/format parameters, a valid/ready handshake on both sides, channel tagging, zero/negative handling and output saturation.

## Interface
- IN_W, 32, input sample width (signed two's complement)
- IN_Q, 30, input fractional bits
- OUT_W, 16, output width (signed)
- OUT_Q, 11, output fractional bits, which is also the number of squaring iterations
- CH_W, 5, channel tag width (32 mel bins)
- GUARD, 4, extra mantissa fraction bits kept during squaring; MANT_F = OUT_Q+GUARD
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample valid
- in_ready  out  1  unit can accept a sample
- in_data  in  IN_W  mel energy, Q(IN_Q)
- in_ch  in  CH_W  mel channel index
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  log result, Q(OUT_Q)
- out_ch  out  CH_W  channel index captured with the sample
- out_zero  out  1  input was ≤0; out_data forced to the most negative value
- out_sat  out  1  result was clipped to the OUT_W range

## Operation
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; out_valid, out_data, out_ch, out_zero and out_sat are all 0; state is IDLE.
- IDLE: in_ready=1. When in_valid is high, capture in_data and in_ch, then go to NORM.
- NORM (1 cycle):
  - If the sample is ≤0, set out_zero=1, out_data=-2^(OUT_W-1), and go to DONE.
  - Otherwise find the MSB position p (0..IN_W-2). Set int_part = p-IN_Q (signed).
  - Set mantissa = sample left-aligned so that m ∈ [1,2), held as Q1.MANT_F. Truncate lower bits.
  - Clear the fraction accumulator and the iteration counter, then go to SQR.
- SQR (OUT_Q cycles), each cycle:
  - Compute m² and truncate it to Q2.MANT_F.
  - If m² ≥ 2: shift a 1 into the fraction accumulator and set m = m²/2.
  - Otherwise: shift a 0 in and set m = m².
  - Increment the counter. After iteration OUT_Q, go to DONE.
- DONE entry:
  - Form the result as (int_part<<OUT_Q) | frac.
  - If the result lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], clamp it and set out_sat=1.
  - Register out_data, out_ch and the flags, and assert out_valid.
- DONE: hold all outputs stable while out_ready=0. On out_valid&&out_ready, clear out_valid and go to IDLE.
- Fraction arithmetic is truncating (floor). The result is within 1 LSB of the exact floor(log2·2^OUT_Q).

## Timing
- The input is accepted at cycle 0, when in_valid&&in_ready.
- NORM is cycle 1, SQR is cycles 2..OUT_Q+1, and out_valid rises at cycle OUT_Q+2 (13 for the defaults). A zero or negative input gives out_valid at cycle 2.
- No pipelining: there is one sample in flight and in_ready=0 outside IDLE.
- Back-to-back minimum interval is OUT_Q+3 cycles when out_ready is held high.
- in_valid asserted outside IDLE is ignored. The upstream must hold the sample until in_ready.
- rst asserted in any state aborts the computation. The unit returns to reset values on the next edge and emits no partial result.

## Configuration
- LOG_LN_SCALE_EN defined:
  - An extra SCALE state (1 cycle) runs between SQR and DONE.
  - It multiplies the unclamped result by ln2 = 45426 (Q16), rounds half away from zero, then saturates. The output is the natural log in Q(OUT_Q).
  - Latency becomes OUT_Q+3. out_zero behaviour is unchanged.
- LOG_LN_SCALE_EN undefined: output is log2, with no SCALE state and no multiplier.

## Structure
- Shared package mfcc_pkg:
  - state enum (IDLE, NORM, SQR, SCALE, DONE)
  - LN2_Q16 constant
  - function computing MANT_F
  - saturation helper function
- One sub-module, mfcc_lod: a parametrised combinational leading-one detector that returns p and a valid bit. It is reused by later normalisation stages.

## Test plan
- in_data=0x40000000 (1.0), ch=3 -> out_data=0x0000, out_ch=3, flags 0, out_valid at cycle 13.
- in_data=0x20000000 (0.5) -> out_data=0xF800 (-2048). With LOG_LN_SCALE_EN: -1420 (0xFA74).
- in_data=0x60000000 (1.5) -> out_data=1198 ±1 LSB (0x04AE).
- in_data=0x00000001 -> log2=-30 clamps to 0x8000 with out_sat=1. in_data=0 or 0xFFFFFFF0 -> 0x8000 with out_zero=1 at cycle 2.
- Back-to-back samples with out_ready held low for 5 cycles after out_valid -> out_data and out_ch stay stable, in_ready stays 0, and the second sample is accepted the cycle after the handshake.
- rst pulsed at SQR iteration 5 -> all outputs 0 next cycle. A fresh 1.0 sample then gives 0x0000 with no stale fraction bits.

Source files
------------

// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared types, constants and helpers for the MFCC front-end
// log stage.
//   state_e    - controller states of the iterative log unit
//   LN2_Q16    - ln(2) in Q16, used to convert log2 to ln
//   sat_res_t  - clipped value plus a flag saying whether clipping happened
//   calc_mant_f(), sat_clip() - helper functions
package mfcc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    SQR   = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int LN2_Q16 = 45426;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Mantissa fraction bits carried through the squaring loop.
  function automatic int calc_mant_f(input int out_q, input int guard);
    return out_q + guard;
  endfunction

  // Clip a signed value to the range of a w-bit two's complement number.
  function automatic sat_res_t sat_clip(input logic signed [63:0] v, input int w);
    sat_res_t           r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mfcc_lod.sv
// mfcc_lod: combinational leading-one detector.
//   data_i  [W]  - word to search
//   pos_o   [PW] - bit index of the most significant 1
//   valid_o      - 1 when data_i contains at least one 1
module mfcc_lod #(
  parameter  int W  = 31,
  localparam int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  data_i,
  output logic [PW-1:0] pos_o,
  output logic          valid_o
);

  // Ascending scan: the last hit is the most significant one.
  always_comb begin
    pos_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        pos_o   = PW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfcc_log2_iter.sv
// mfcc_log2_iter: iterative fixed-point log2 (optionally ln) of one
// non-negative mel-energy sample per handshake.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake; in_data Q(IN_Q), in_ch tag
//   out_valid/out_ready   - output handshake
//   out_data              - log result Q(OUT_Q), signed
//   out_ch                - channel tag captured with the sample
//   out_zero              - input was <= 0, out_data is the most negative value
//   out_sat               - result was clipped to OUT_W bits
// Build option: define LOG_LN_SCALE_EN to convert the result to natural log
// in an extra SCALE cycle.
//
// state | meaning
// IDLE  | ready for a sample
// NORM  | leading-one normalisation, zero/negative detection
// SQR   | one squaring iteration (one result bit) per cycle
// SCALE | multiply by ln2 (LOG_LN_SCALE_EN builds only)
// DONE  | result held until out_ready
module mfcc_log2_iter
  import mfcc_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int IN_Q  = 30,
  parameter int OUT_W = 16,
  parameter int OUT_Q = 11,
  parameter int CH_W  = 5,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_zero,
  output logic             out_sat
);

  localparam int MANT_F = calc_mant_f(OUT_Q, GUARD);
  localparam int MW     = MANT_F + 1;             // Q1.MANT_F mantissa width
  localparam int LW     = IN_W - 1;               // magnitude bits of the sample
  localparam int PW     = (LW > 1) ? $clog2(LW) : 1;
  localparam int EXT_W  = LW + MW;
  localparam int CW     = $clog2(OUT_Q + 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    sample_q, sample_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic signed [31:0] int_q, int_d;
  logic [MW-1:0]      mant_q, mant_d;
  logic [OUT_Q-1:0]   frac_q, frac_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;
  logic               out_zero_q, out_zero_d;
  logic               out_sat_q, out_sat_d;

  logic [PW-1:0]      lod_pos;
  logic               lod_valid;
  logic [EXT_W-1:0]   ext_sh;
  logic [MW-1:0]      mant_norm;
  logic [2*MW-1:0]    sq;
  logic [MW:0]        sq_t;
  logic               sq_ge2;
  logic [MW-1:0]      mant_nx;
  logic [OUT_Q:0]     frac_ext;
  logic [OUT_Q-1:0]   frac_nx;
  logic [OUT_Q-1:0]   frac_fin;
  logic signed [63:0] res_raw;
  logic signed [63:0] sat_in;
  sat_res_t           res_sat;
  logic [OUT_W-1:0]   res_out;

  mfcc_lod #(.W(LW)) u_lod (
    .data_i  (sample_q[LW-1:0]),
    .pos_o   (lod_pos),
    .valid_o (lod_valid)
  );

  // Datapath: normalisation, one squaring step, result assembly.
  always_comb begin
    // Move the leading one to the top of the extended word; the top MW bits
    // are then the mantissa in [1,2), lower bits truncated.
    ext_sh    = {sample_q[LW-1:0], {MW{1'b0}}} << (PW'(LW - 1) - lod_pos);
    mant_norm = MW'(ext_sh >> (EXT_W - MW));

    // m^2 is Q2.(2*MANT_F); keep Q2.MANT_F.
    sq       = mant_q * mant_q;
    sq_t     = (MW + 1)'(sq >> MANT_F);
    sq_ge2   = sq_t[MW];
    mant_nx  = sq_ge2 ? sq_t[MW:1] : sq_t[MW-1:0];
    frac_ext = {frac_q, sq_ge2};
    frac_nx  = frac_ext[OUT_Q-1:0];

`ifdef LOG_LN_SCALE_EN
    frac_fin = frac_q;
`else
    frac_fin = frac_nx;
`endif

    // Low OUT_Q bits of the shifted integer part are zero, so OR is an add.
    res_raw = (64'(int_q) <<< OUT_Q) | 64'(frac_fin);
  end

`ifdef LOG_LN_SCALE_EN
  logic signed [63:0] prod;
  logic signed [63:0] scaled;

  // ln(x) = log2(x) * ln2, rounded half away from zero.
  always_comb begin
    prod = res_raw * 64'(LN2_Q16);
    if (prod < 0) begin
      scaled = -((-prod + 64'sd32768) >>> 16);
    end else begin
      scaled = (prod + 64'sd32768) >>> 16;
    end
    sat_in = scaled;
  end
`else
  always_comb begin
    sat_in = res_raw;
  end
`endif

  always_comb begin
    res_sat = sat_clip(sat_in, OUT_W);
    res_out = OUT_W'(res_sat.val);
  end

  // Next-state / register-update logic.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    ch_d        = ch_q;
    int_d       = int_q;
    mant_d      = mant_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_zero_d  = out_zero_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sample_d = in_data;
          ch_d     = in_ch;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (sample_q[IN_W-1] || !lod_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = {1'b1, {(OUT_W-1){1'b0}}};
          out_ch_d    = ch_q;
          out_zero_d  = 1'b1;
          out_sat_d   = 1'b0;
          state_d     = DONE;
        end else begin
          int_d   = 32'(lod_pos) - 32'(IN_Q);
          mant_d  = mant_norm;
          frac_d  = '0;
          cnt_d   = '0;
          state_d = SQR;
        end
      end

      SQR: begin
        mant_d = mant_nx;
        frac_d = frac_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(OUT_Q - 1)) begin
`ifdef LOG_LN_SCALE_EN
          state_d = SCALE;
`else
          out_valid_d = 1'b1;
          out_data_d  = res_out;
          out_ch_d    = ch_q;
          out_zero_d  = 1'b0;
          out_sat_d   = res_sat.sat;
          state_d     = DONE;
`endif
        end
      end

`ifdef LOG_LN_SCALE_EN
      SCALE: begin
        out_valid_d = 1'b1;
        out_data_d  = res_out;
        out_ch_d    = ch_q;
        out_zero_d  = 1'b0;
        out_sat_d   = res_sat.sat;
        state_d     = DONE;
      end
`endif

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      ch_q        <= '0;
      int_q       <= '0;
      mant_q      <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_zero_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      ch_q        <= ch_d;
      int_q       <= int_d;
      mant_q      <= mant_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_zero_q  <= out_zero_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Gated by rst so the unit never looks ready while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_zero  = out_zero_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mfcc_log2_iter.sv
// tb_mfcc_log2_iter: directed self-checking bench for mfcc_log2_iter.
// Expected values follow the LOG_LN_SCALE_EN setting of the build.
module tb_mfcc_log2_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [4:0]  out_ch;
  logic        out_zero;
  logic        out_sat;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef LOG_LN_SCALE_EN
  localparam int LAT     = 14;
  localparam int HALF    = -1420;
  localparam int P15_LO  = 829;
  localparam int P15_HI  = 831;
`else
  localparam int LAT     = 13;
  localparam int HALF    = -2048;
  localparam int P15_LO  = 1197;
  localparam int P15_HI  = 1199;
`endif

  always #5 clk = ~clk;

  mfcc_log2_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_zero  (out_zero),
    .out_sat   (out_sat)
  );

  // Present one sample once in_ready is seen and count clock edges until
  // out_valid (1 = first edge after the accepting edge's cycle began).
  task automatic send(input logic [31:0] d, input logic [4:0] ch, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = ch;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    tests_run++;
    if ({out_valid, out_zero, out_sat} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 000", {out_valid, out_zero, out_sat});
    end
    tests_run++;
    if (out_data !== 16'h0000 || out_ch !== 5'd0) begin
      tests_failed++; $display("FAIL reset_data: got %h/%0d expected 0000/0", out_data, out_ch);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_unity();
    int lat;
    send(32'h4000_0000, 5'd3, lat);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++; $display("FAIL unity_latency: got %0d expected %0d", lat, LAT);
    end
    tests_run++;
    if (out_data !== 16'h0000 || out_ch !== 5'd3) begin
      tests_failed++; $display("FAIL unity_data: got %h/%0d expected 0000/3", out_data, out_ch);
    end
    tests_run++;
    if ({out_zero, out_sat} !== 2'b00) begin
      tests_failed++; $display("FAIL unity_flags: got %b expected 00", {out_zero, out_sat});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_half();
    int lat;
    logic [15:0] exp_d;
    exp_d = 16'(HALF);
    send(32'h2000_0000, 5'd1, lat);
    tests_run++;
    if (out_data !== exp_d || out_ch !== 5'd1 || out_sat !== 1'b0) begin
      tests_failed++; $display("FAIL half: got %h/%0d sat=%b expected %h/1 sat=0", out_data, out_ch, out_sat, exp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_one_p5();
    int lat;
    int v;
    send(32'h6000_0000, 5'd2, lat);
    v = int'($signed(out_data));
    tests_run++;
    if (v < P15_LO || v > P15_HI || out_ch !== 5'd2) begin
      tests_failed++; $display("FAIL one_p5: got %0d/%0d expected %0d..%0d/2", v, out_ch, P15_LO, P15_HI);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tiny_sat();
    int lat;
    send(32'h0000_0001, 5'd31, lat);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++; $display("FAIL tiny_latency: got %0d expected %0d", lat, LAT);
    end
    tests_run++;
    if (out_data !== 16'h8000 || {out_zero, out_sat} !== 2'b01 || out_ch !== 5'd31) begin
      tests_failed++; $display("FAIL tiny_sat: got %h z/s=%b ch=%0d expected 8000 z/s=01 ch=31", out_data, {out_zero, out_sat}, out_ch);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_neg();
    int lat;
    send(32'h0000_0000, 5'd5, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL zero_latency: got %0d expected 2", lat);
    end
    tests_run++;
    if (out_data !== 16'h8000 || {out_zero, out_sat} !== 2'b10 || out_ch !== 5'd5) begin
      tests_failed++; $display("FAIL zero: got %h z/s=%b ch=%0d expected 8000 z/s=10 ch=5", out_data, {out_zero, out_sat}, out_ch);
    end
    @(posedge clk); #1;
    send(32'hFFFF_FFF0, 5'd6, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL neg_latency: got %0d expected 2", lat);
    end
    tests_run++;
    if (out_data !== 16'h8000 || {out_zero, out_sat} !== 2'b10 || out_ch !== 5'd6) begin
      tests_failed++; $display("FAIL neg: got %h z/s=%b ch=%0d expected 8000 z/s=10 ch=6", out_data, {out_zero, out_sat}, out_ch);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int v;
    logic [15:0] exp_d;
    exp_d = 16'(HALF);
    out_ready = 1'b0;
    send(32'h6000_0000, 5'd7, lat);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT);
    end
    // Second sample offered while the first result is stalled.
    in_valid = 1'b1;
    in_data  = 32'h2000_0000;
    in_ch    = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      v = int'($signed(out_data));
      tests_run++;
      if (out_valid !== 1'b1 || v < P15_LO || v > P15_HI || out_ch !== 5'd7 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: got v=%b d=%0d ch=%0d rdy=%b expected v=1 d=%0d..%0d ch=7 rdy=0",
                 i, out_valid, v, out_ch, in_ready, P15_LO, P15_HI);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_handshake: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_second_accept: got rdy=%b expected 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    tests_run++;
    if (lat !== LAT || out_data !== exp_d || out_ch !== 5'd9) begin
      tests_failed++; $display("FAIL b2b_second: got lat=%0d %h/%0d expected lat=%0d %h/9", lat, out_data, out_ch, LAT, exp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_abort();
    int lat;
    int w;
    logic seen;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    in_data  = 32'h6000_0000;
    in_ch    = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL abort_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({out_valid, out_zero, out_sat} !== 3'b000 || out_data !== 16'h0000 || out_ch !== 5'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got v/z/s=%b %h/%0d expected 000 0000/0", {out_valid, out_zero, out_sat}, out_data, out_ch);
    end
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL abort_ready_after: got %b expected 1", in_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_partial: got out_valid seen=%b expected 0", seen);
    end
    send(32'h4000_0000, 5'd6, lat);
    tests_run++;
    if (lat !== LAT || out_data !== 16'h0000 || out_ch !== 5'd6 || {out_zero, out_sat} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_fresh: got lat=%0d %h/%0d z/s=%b expected lat=%0d 0000/6 z/s=00", lat, out_data, out_ch, {out_zero, out_sat}, LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_half();
    test_one_p5();
    test_tiny_sat();
    test_zero_neg();
    test_back_to_back();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
